dac7311_ctrl: RTL and testbench
===============================

Name: dac7311_ctrl

Overview:
- Serial DAC write controller. It is the transmit counterpart of the ADS7883 capture path and drives a DAC7311-class 12-bit DAC over its 3-wire interface (SYNC, SCLK, DIN).
- Accepts one signed 12-bit sample per request and converts it to offset binary.
- Shifts a 16-bit frame MSB-first and reports busy/done to the upstream sample source, typically the processed ADC stream.

Parameters:
- CLK_STEP, 4: system clocks per SCLK half-period. Legal range 2..255.
- PD_MODE, 2'b00: power-down bits placed in frame[15:14]. 00 means normal operation.
- SIGNED_IN, 1: when 1, code = dac_data ^ 12'h800 (two's complement to offset binary). When 0, code = dac_data unchanged.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- dac_req  input  1  start request, sampled in IDLE only
- dac_data  input  12  signed sample, captured on the accept cycle
- dac_busy  output  1  high from the cycle after accept until the end of the gap
- dac_done  output  1  one-cycle pulse when the frame completes
- dac_sclk  output  1  DAC serial clock, idles high
- dac_sync  output  1  DAC frame sync, active-low, idles high
- dac_din  output  1  DAC serial data, changes only while SCLK is high

Behaviour:
- Reset (async, rst=1) forces outputs and state immediately:
  - dac_sync=1, dac_sclk=1, dac_din=0, dac_busy=0, dac_done=0
  - shift register=0, counters=0, state=IDLE
- Frame format: frame[15:0] = {PD_MODE, code[11:0], 2'b00}. Transmitted MSB (bit15) first.
- State machine: IDLE -> SHIFT -> GAP -> IDLE.
- IDLE:
  - If dac_req=1 on a clk edge (the accept cycle), latch the frame from dac_data.
  - Next cycle (t0): dac_sync=0, dac_din=frame[15], dac_sclk=1, dac_busy=1, enter SHIFT.
  - dac_req=0 keeps the block in IDLE with outputs at idle values.
- SHIFT: a half-period counter runs 0..CLK_STEP-1.
  - dac_sclk falls at t0+(2k+1)*CLK_STEP, for k=0..15. The DAC samples DIN on this edge.
  - dac_sclk rises at t0+(2k+2)*CLK_STEP.
  - On each rise with k<15, dac_din takes frame[14-k].
  - On the 16th rise (t0+32*CLK_STEP): dac_sync=1, dac_din=0, dac_done=1 for exactly that cycle, enter GAP.
- GAP: dac_sync held high, dac_busy stays 1 for CLK_STEP cycles. dac_busy=0 at t0+33*CLK_STEP, return to IDLE.
- Exactly 16 falling SCLK edges occur while dac_sync=0. No SCLK edge coincides with a SYNC edge.
- Request handling:
  - dac_req while busy (SHIFT/GAP) is ignored. No queueing.
  - dac_data changes during a frame do not affect the frame in flight.
  - dac_req held continuously high gives back-to-back frames. The next accept is the first IDLE cycle, so the accept-to-accept period is 33*CLK_STEP+1 clocks.
- Reset mid-frame: aborts immediately to idle levels. The partial frame is discarded (the DAC ignores frames with fewer than 16 falling edges). No dac_done is issued.
- Width rules:
  - Bit counter is 5 bits, counting 0..16.
  - Half-period counter is 8 bits.
  - No arithmetic on data beyond the MSB inversion.

Test Plan:
- CLK_STEP=4, SIGNED_IN=1, dac_data=12'h000, one req -> SYNC low 128 clocks, 16 falls, bits captured on falls = 16'h2000, dac_done pulse at t0+128, busy low at t0+132.
- dac_data=12'h800 (-2048) -> frame 16'h0000; dac_data=12'h7FF (+2047) -> frame 16'h3FFC; SIGNED_IN=0 with 12'hABC -> frame 16'h2AF0.
- PD_MODE=2'b11, dac_data=12'h000 -> frame 16'hE000, first two DIN bits 1,1.
- dac_req pulsed at t0+50 mid-frame, with dac_data changed to 12'h123 -> ignored, frame unchanged, only one dac_done.
- dac_req held high for 3 frames, CLK_STEP=2 -> accepts spaced 67 clocks, SYNC high ≥2 clocks between frames, 3 dac_done pulses.
- rst asserted at t0+40 -> same-cycle sync=1, sclk=1, din=0, busy=0, no done; after release, a new req gives a complete correct frame.

Source files
------------

// File: rtl/dac7311_ctrl.sv
// DAC7311 3-wire write controller: latches one 12-bit sample per request and shifts a 16-bit frame MSB-first.
// Accept-to-accept period is 33*CLK_STEP+1 clocks. Requests that arrive while busy are dropped, not queued.
module dac7311_ctrl #(
    parameter int         CLK_STEP  = 4,
    parameter logic [1:0] PD_MODE   = 2'b00,
    parameter bit         SIGNED_IN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dac_req,
    input  logic [11:0] dac_data,
    output logic        dac_busy,
    output logic        dac_done,
    output logic        dac_sclk,
    output logic        dac_sync,
    output logic        dac_din
);

    localparam logic [7:0] STEP_LAST = 8'(CLK_STEP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] shreg;
    logic [4:0]  bit_cnt;
    logic [7:0]  half_cnt;
    logic [11:0] code;
    logic [15:0] frame;
    logic        half_tick;

    assign code      = SIGNED_IN ? (dac_data ^ 12'h800) : dac_data;
    assign frame     = {PD_MODE, code, 2'b00};
    assign half_tick = (half_cnt == STEP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= 16'h0000;
            bit_cnt  <= 5'd0;
            half_cnt <= 8'd0;
            dac_busy <= 1'b0;
            dac_done <= 1'b0;
            dac_sclk <= 1'b1;
            dac_sync <= 1'b1;
            dac_din  <= 1'b0;
        end else begin
            dac_done <= 1'b0;
            case (state)
                IDLE: begin
                    half_cnt <= 8'd0;
                    bit_cnt  <= 5'd0;
                    if (dac_req) begin
                        shreg    <= frame;
                        dac_din  <= frame[15];
                        dac_sync <= 1'b0;
                        dac_busy <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!half_tick) begin
                        half_cnt <= half_cnt + 8'd1;
                    end else begin
                        half_cnt <= 8'd0;
                        if (dac_sclk) begin
                            // falling edge: the DAC samples DIN here
                            dac_sclk <= 1'b0;
                            bit_cnt  <= bit_cnt + 5'd1;
                        end else begin
                            dac_sclk <= 1'b1;
                            if (bit_cnt == 5'd16) begin
                                dac_sync <= 1'b1;
                                dac_din  <= 1'b0;
                                dac_done <= 1'b1;
                                state    <= GAP;
                            end else begin
                                dac_din <= shreg[14];
                                shreg   <= shreg << 1;
                            end
                        end
                    end
                end
                GAP: begin
                    if (!half_tick) begin
                        half_cnt <= half_cnt + 8'd1;
                    end else begin
                        half_cnt <= 8'd0;
                        bit_cnt  <= 5'd0;
                        shreg    <= 16'h0000;
                        dac_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac7311_ctrl.sv
// Bench for dac7311_ctrl: four parameterisations driven by random and directed samples,
// frames reassembled from DIN on SCLK falls and compared with an arithmetic reference.
module tb_dac7311_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req  [4];
    logic [11:0] data [4];
    logic        busy [4];
    logic        done [4];
    logic        sclk [4];
    logic        sync [4];
    logic        din  [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dac7311_ctrl #(.CLK_STEP(4), .PD_MODE(2'b00), .SIGNED_IN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .dac_req(req[0]), .dac_data(data[0]), .dac_busy(busy[0]),
        .dac_done(done[0]), .dac_sclk(sclk[0]), .dac_sync(sync[0]), .dac_din(din[0]));
    dac7311_ctrl #(.CLK_STEP(4), .PD_MODE(2'b00), .SIGNED_IN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .dac_req(req[1]), .dac_data(data[1]), .dac_busy(busy[1]),
        .dac_done(done[1]), .dac_sclk(sclk[1]), .dac_sync(sync[1]), .dac_din(din[1]));
    dac7311_ctrl #(.CLK_STEP(4), .PD_MODE(2'b11), .SIGNED_IN(1'b1)) dut2 (
        .clk(clk), .rst(rst), .dac_req(req[2]), .dac_data(data[2]), .dac_busy(busy[2]),
        .dac_done(done[2]), .dac_sclk(sclk[2]), .dac_sync(sync[2]), .dac_din(din[2]));
    dac7311_ctrl #(.CLK_STEP(2), .PD_MODE(2'b00), .SIGNED_IN(1'b1)) dut3 (
        .clk(clk), .rst(rst), .dac_req(req[3]), .dac_data(data[3]), .dac_busy(busy[3]),
        .dac_done(done[3]), .dac_sclk(sclk[3]), .dac_sync(sync[3]), .dac_din(din[3]));

    function automatic int step_of(input int idx);
        return (idx == 3) ? 2 : 4;
    endfunction

    // Reference: signed sample -> offset binary by adding 2048, then placed above two zero pad bits.
    function automatic logic [15:0] model_frame(input int idx, input logic [11:0] d);
        int pd;
        int v;
        int code;
        pd = (idx == 2) ? 3 : 0;
        v  = int'(d);
        if (idx == 1) begin
            code = v;
        end else begin
            if (v >= 2048) v = v - 4096;
            code = v + 2048;
        end
        return 16'(pd * 16384 + code * 4);
    endfunction

    // Issues one request and observes the frame; n counts clock edges since the accept edge.
    task automatic run_frame(input int idx, input logic [11:0] d, input int inject_n,
                             output logic [15:0] bits, output int nfalls, output int badpos,
                             output int sync_low, output int ndone, output int done_n,
                             output int busy_off_n, output int din_viol, output bit start_ok);
        int   s;
        logic ps;
        logic pdin;
        s = step_of(idx);
        bits = 16'h0000; nfalls = 0; badpos = 0; sync_low = 0; ndone = 0;
        done_n = -1; busy_off_n = -1; din_viol = 0; start_ok = 1'b0;
        @(negedge clk);
        req[idx]  = 1'b1;
        data[idx] = d;
        @(posedge clk);
        ps   = 1'b1;
        pdin = 1'b0;
        for (int n = 0; n < 40 * s + 10; n++) begin
            @(negedge clk);
            if (n == 0) begin
                req[idx]  = 1'b0;
                data[idx] = 12'($urandom_range(0, 4095));
                start_ok  = (sync[idx] === 1'b0) && (busy[idx] === 1'b1) && (sclk[idx] === 1'b1);
            end
            if (n == inject_n) begin
                req[idx]  = 1'b1;
                data[idx] = 12'h123;
            end else if (n == inject_n + 1) begin
                req[idx] = 1'b0;
            end
            if (sync[idx] === 1'b0) sync_low++;
            if (ps === 1'b1 && sclk[idx] === 1'b0) begin
                if (sync[idx] === 1'b0) bits = {bits[14:0], din[idx]};
                if (n != (2 * nfalls + 1) * s) badpos++;
                nfalls++;
            end
            if (din[idx] !== pdin && sclk[idx] === 1'b0) din_viol++;
            if (done[idx] === 1'b1) begin
                ndone++;
                done_n = n;
            end
            ps   = sclk[idx];
            pdin = din[idx];
            if (busy[idx] === 1'b0) begin
                busy_off_n = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req[i]  = 1'b0;
            data[i] = 12'h000;
        end
        #12;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({sync[i], sclk[i], din[i], busy[i], done[i]} !== 5'b11000) begin
                errors++;
                $display("FAIL reset_idle dut%0d: {sync,sclk,din,busy,done}=%b expected 11000", i,
                         {sync[i], sclk[i], din[i], busy[i], done[i]});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sync[0], sclk[0], busy[0]} !== 3'b110) begin
            errors++;
            $display("FAIL idle_no_req: {sync,sclk,busy}=%b expected 110", {sync[0], sclk[0], busy[0]});
        end
    endtask

    task automatic test_zero_frame();
        logic [15:0] bits;
        int nf, bp, sl, nd, dn, bo, dv;
        bit so;
        run_frame(0, 12'h000, -10, bits, nf, bp, sl, nd, dn, bo, dv, so);
        checks++;
        if (!so) begin errors++; $display("FAIL t0_levels: sync low/busy high/sclk high not seen at t0"); end
        checks++;
        if (bits !== 16'h2000) begin errors++; $display("FAIL zero_frame: got %h expected 2000", bits); end
        checks++;
        if (nf != 16 || bp != 0) begin errors++; $display("FAIL fall_count: falls=%0d misplaced=%0d expected 16/0", nf, bp); end
        checks++;
        if (sl != 128) begin errors++; $display("FAIL sync_low_len: %0d expected 128", sl); end
        checks++;
        if (nd != 1 || dn != 128) begin errors++; $display("FAIL done_pulse: count=%0d at=%0d expected 1 at 128", nd, dn); end
        checks++;
        if (bo != 132) begin errors++; $display("FAIL busy_release: at=%0d expected 132", bo); end
        checks++;
        if (dv != 0) begin errors++; $display("FAIL din_while_sclk_low: changes=%0d expected 0", dv); end
    endtask

    task automatic test_codes();
        int          tidx [4] = '{0, 0, 1, 2};
        logic [11:0] td   [4] = '{12'h800, 12'h7FF, 12'hABC, 12'h000};
        logic [15:0] texp [4] = '{16'h0000, 16'h3FFC, 16'h2AF0, 16'hE000};
        logic [15:0] bits;
        int nf, bp, sl, nd, dn, bo, dv;
        bit so;
        for (int t = 0; t < 4; t++) begin
            run_frame(tidx[t], td[t], -10, bits, nf, bp, sl, nd, dn, bo, dv, so);
            checks++;
            if (bits !== texp[t] || nf != 16) begin
                errors++;
                $display("FAIL code_frame dut%0d data=%h: got %h falls=%0d expected %h falls=16",
                         tidx[t], td[t], bits, nf, texp[t]);
            end
            if (tidx[t] == 2) begin
                checks++;
                if (bits[15:14] !== 2'b11) begin
                    errors++;
                    $display("FAIL pd_first_bits: got %b expected 11", bits[15:14]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] bits;
        logic [11:0] d;
        int idx, nf, bp, sl, nd, dn, bo, dv;
        bit so;
        for (int t = 0; t < 12; t++) begin
            idx = t % 4;
            d   = 12'($urandom_range(0, 4095));
            run_frame(idx, d, -10, bits, nf, bp, sl, nd, dn, bo, dv, so);
            checks++;
            if (bits !== model_frame(idx, d) || nf != 16 || bp != 0 || nd != 1
                || dn != 32 * step_of(idx) || bo != 33 * step_of(idx)) begin
                errors++;
                $display("FAIL random_frame dut%0d data=%h: got %h falls=%0d misplaced=%0d done=%0d@%0d busy_off=%0d expected %h 16 0 1@%0d %0d",
                         idx, d, bits, nf, bp, nd, dn, bo, model_frame(idx, d),
                         32 * step_of(idx), 33 * step_of(idx));
            end
        end
    endtask

    task automatic test_ignore_busy_req();
        logic [15:0] bits;
        int nf, bp, sl, nd, dn, bo, dv, extra;
        bit so;
        run_frame(0, 12'h456, 50, bits, nf, bp, sl, nd, dn, bo, dv, so);
        checks++;
        if (bits !== model_frame(0, 12'h456)) begin
            errors++;
            $display("FAIL midframe_req_frame: got %h expected %h", bits, model_frame(0, 12'h456));
        end
        checks++;
        if (nd != 1) begin errors++; $display("FAIL midframe_req_done: count=%0d expected 1", nd); end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (sync[0] !== 1'b1 || done[0] !== 1'b0 || busy[0] !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL midframe_req_queued: active cycles=%0d expected 0", extra); end
    endtask

    task automatic test_back_to_back();
        logic ps;
        int nacc, last, badgap, hi_run, min_hi, ndone;
        nacc = 0; last = -1; badgap = 0; hi_run = 0; min_hi = 1000; ndone = 0;
        @(negedge clk);
        req[3]  = 1'b1;
        data[3] = 12'($urandom_range(0, 4095));
        @(posedge clk);
        ps = 1'b1;
        for (int n = 0; n < 250; n++) begin
            @(negedge clk);
            if (ps === 1'b1 && sync[3] === 1'b0) begin
                if (nacc > 0 && n - last != 67) badgap++;
                last = n;
                nacc++;
                if (nacc == 3) req[3] = 1'b0;
            end
            if (sync[3] === 1'b1) begin
                hi_run++;
            end else begin
                if (hi_run > 0 && hi_run < min_hi) min_hi = hi_run;
                hi_run = 0;
            end
            if (done[3] === 1'b1) ndone++;
            ps = sync[3];
        end
        req[3] = 1'b0;
        checks++;
        if (nacc != 3 || badgap != 0) begin
            errors++;
            $display("FAIL b2b_spacing: accepts=%0d bad_gaps=%0d expected 3/0", nacc, badgap);
        end
        checks++;
        if (min_hi < 2 || min_hi == 1000) begin
            errors++;
            $display("FAIL b2b_sync_gap: min high run=%0d expected >=2", min_hi);
        end
        checks++;
        if (ndone != 3) begin errors++; $display("FAIL b2b_done_count: %0d expected 3", ndone); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] bits;
        logic [11:0] d;
        int nf, bp, sl, nd, dn, bo, dv, spurious;
        bit so;
        @(negedge clk);
        req[0]  = 1'b1;
        data[0] = 12'h3C5;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        repeat (39) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({sync[0], sclk[0], din[0], busy[0], done[0]} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_midframe: {sync,sclk,din,busy,done}=%b expected 11000",
                     {sync[0], sclk[0], din[0], busy[0], done[0]});
        end
        spurious = 0;
        repeat (3) begin
            @(negedge clk);
            if (done[0] !== 1'b0) spurious++;
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done[0] !== 1'b0 || sync[0] !== 1'b1) spurious++;
        end
        checks++;
        if (spurious != 0) begin errors++; $display("FAIL reset_no_done: bad cycles=%0d expected 0", spurious); end
        d = 12'($urandom_range(0, 4095));
        run_frame(0, d, -10, bits, nf, bp, sl, nd, dn, bo, dv, so);
        checks++;
        if (bits !== model_frame(0, d) || nd != 1 || bo != 132) begin
            errors++;
            $display("FAIL post_reset_frame: got %h done=%0d busy_off=%0d expected %h 1 132",
                     bits, nd, bo, model_frame(0, d));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_frame();
        test_codes();
        test_random();
        test_ignore_busy_req();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
